// File: rtl/pkt_proc_enq_arbiter.sv
// Packet-granular round-robin arbiter that shares the packet processor's single
// enqueue port between NUM_SRC sources, with one registered output stage.
module pkt_proc_enq_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 32,
  parameter int LEN_W   = 12,
  parameter int CNT_W   = 16,
  localparam int IDX_W  = $clog2(NUM_SRC)
) (
  input  logic                      pck_proc_int_mem_fsm_clk,
  input  logic                      pck_proc_int_mem_fsm_rst,
  input  logic                      sw_clr,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC-1:0]        src_sop,
  input  logic [NUM_SRC-1:0]        src_eop,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC*LEN_W-1:0]  src_len,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      enq_req,
  output logic                      in_sop,
  output logic                      in_eop,
  output logic [DATA_W-1:0]         wr_data_i,
  output logic                      pck_len_valid,
  output logic [LEN_W-1:0]          pck_len_i,
  input  logic                      pck_proc_full,
  input  logic                      pck_proc_almost_full,
  input  logic                      packet_drop,
  output logic [IDX_W-1:0]          grant_idx,
  output logic                      busy,
  output logic                      proto_err,
  output logic [NUM_SRC*CNT_W-1:0]  src_pkt_cnt,
  output logic [CNT_W-1:0]          drop_cnt
);

  typedef enum logic [0:0] {IDLE, XFER} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_grant_q;
  logic              first_q;
  logic              enq_q, sop_q, eop_q, lenv_q, perr_q;
  logic [DATA_W-1:0] data_q;
  logic [LEN_W-1:0]  len_q;
  logic [CNT_W-1:0]  cnt_q [NUM_SRC];
  logic [CNT_W-1:0]  drop_q;

  logic [NUM_SRC-1:0] elig;
  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic               accept;
  logic               sel_sop, sel_eop;
  logic [DATA_W-1:0]  sel_data;
  logic [LEN_W-1:0]   sel_len;

  assign elig     = src_valid & src_sop;
  assign sel_sop  = src_sop[grant_q];
  assign sel_eop  = src_eop[grant_q];
  assign sel_data = src_data[int'(grant_q)*DATA_W +: DATA_W];
  assign sel_len  = src_len[int'(grant_q)*LEN_W +: LEN_W];

  // Search starts one past the last completed grant, wrapping modulo NUM_SRC.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_SRC);
      if (!found && elig[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    src_ready = '0;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (found && !pck_proc_almost_full) begin
          grant_d = winner;
          state_d = XFER;
        end
      end
      XFER: begin
        src_ready[grant_q] = ~pck_proc_full;
        accept             = src_valid[grant_q] & ~pck_proc_full;
        if (accept && sel_eop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pck_proc_int_mem_fsm_clk or posedge pck_proc_int_mem_fsm_rst) begin
    if (pck_proc_int_mem_fsm_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_SRC - 1);
      first_q      <= 1'b0;
      enq_q        <= 1'b0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      lenv_q       <= 1'b0;
      perr_q       <= 1'b0;
      data_q       <= '0;
      len_q        <= '0;
      drop_q       <= '0;
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (state_q == IDLE && state_d == XFER) first_q <= 1'b1;
      else if (accept)                        first_q <= 1'b0;

      enq_q  <= accept;
      sop_q  <= accept & sel_sop;
      eop_q  <= accept & sel_eop;
      lenv_q <= accept & sel_sop;
      // A repeated SOP inside a packet is forwarded as-is; only flagged.
      perr_q <= accept & sel_sop & ~first_q;
      if (accept)            data_q <= sel_data;
      if (accept && sel_sop) len_q  <= sel_len;

      if (sw_clr) begin
        last_grant_q <= IDX_W'(NUM_SRC - 1);
        drop_q       <= '0;
        for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
      end else begin
        if (accept && sel_eop) begin
          last_grant_q <= grant_q;
          if (cnt_q[grant_q] != '1) cnt_q[grant_q] <= cnt_q[grant_q] + 1'b1;
        end
        if (packet_drop && drop_q != '1) drop_q <= drop_q + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_cnt
    assign src_pkt_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign enq_req       = enq_q;
  assign in_sop        = sop_q;
  assign in_eop        = eop_q;
  assign wr_data_i     = data_q;
  assign pck_len_valid = lenv_q;
  assign pck_len_i     = len_q;
  assign grant_idx     = grant_q;
  assign busy          = (state_q == XFER);
  assign proto_err     = perr_q;
  assign drop_cnt      = drop_q;

endmodule
